// File: rtl/ctrl_interface_pkg.sv
// Shared command codes and data-out select codes for the multi-channel
// NoC interface controller.
package ctrl_interface_pkg;

    typedef enum logic [4:0] {
        CONF_REG  = 5'd0,
        MEM_IN    = 5'd1,
        MEM_OUT   = 5'd2,
        CR_WR_PTR = 5'd3,
        MI_WR_PTR = 5'd4,
        MO_RD_PTR = 5'd5,
        CH_SEL    = 5'd6,
        STAT_REG  = 5'd30,
        ID_REG    = 5'd31
    } conf_cmd_e;

    localparam int MUX_ID     = 0;
    localparam int MUX_STAT   = 1;
    localparam int MUX_CONF   = 2;
    localparam int MUX_MEMOUT = 3;
    localparam int MUX_MEMIN  = 4;
    localparam int MUX_CR_PTR = 5;
    localparam int MUX_MI_PTR = 6;
    localparam int MUX_MO_PTR = 7;
    localparam int MUX_CH_SEL = 8;

endpackage

// File: rtl/ctrl_interface_mc_addr_ptr.sv
// Post-incrementing address pointer with load, wrap at DEPTH-1 and a
// single-cycle wrap pulse that coincides with the wrapping strobe.
module addr_ptr #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr,
    output logic             wrap
);

    localparam logic [WIDTH:0]   DEPTH_W = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;
    logic             at_last;

    always_comb begin
        at_last = (ptr_q == LAST);
        wrap    = inc & ~load & at_last;
        ptr_d   = ptr_q;
        if (load) begin
            // Start values beyond the memory depth fall back to address 0.
            ptr_d = ({1'b0, load_val} >= DEPTH_W) ? '0 : load_val;
        end else if (inc) begin
            ptr_d = at_last ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ctrl_interface_mc.sv
// Multi-channel NoC interface controller: decodes protocol commands into
// memory/config strobes, per-memory address pointers, channel select and wrap flags.
module ctrl_interface_mc
    import ctrl_interface_pkg::*;
#(
    parameter int NUM_MEMI        = 2,
    parameter int NUM_MEMO        = 2,
    parameter int CH_WIDTH        = 2,
    parameter int ADDR_WIDTH_PTR  = 6,
    parameter int ADDR_WIDTH_MEMI = 6,
    parameter int ADDR_WIDTH_MEMO = 6,
    parameter int ADDR_WIDTH_CR   = 1,
    parameter int DEPTH_MEMI      = 64,
    parameter int DEPTH_MEMO      = 64,
    parameter int SIZE_MUX        = 4
) (
    input  logic                                clk,
    input  logic                                rst_a,
    input  logic                                en_s,
    input  logic                                read,
    input  logic                                write,
    input  logic [4:0]                          conf_dbus,
    input  logic [ADDR_WIDTH_PTR-1:0]           init_ptr,
    output logic [SIZE_MUX-1:0]                 sel_mux,
    output logic [CH_WIDTH-1:0]                 ch_sel,
    output logic [ADDR_WIDTH_CR-1:0]            wr_addr_ConfigReg,
    output logic [NUM_MEMI*ADDR_WIDTH_MEMI-1:0] wr_addr_MemIn,
    output logic [NUM_MEMO*ADDR_WIDTH_MEMO-1:0] rd_addr_MemOut,
    output logic                                wr_en_ConfigReg,
    output logic [NUM_MEMI-1:0]                 wr_en_MemIn,
    output logic [NUM_MEMO-1:0]                 rd_en_MemOut,
    output logic                                en_clear,
    output logic [NUM_MEMI+NUM_MEMO-1:0]        wrap_flags
);

    logic                         active;
    logic                         mi_wr;
    logic                         mo_rd;
    logic                         cr_ld;
    logic                         mi_ld;
    logic                         mo_ld;
    logic                         ch_ld;
    logic [NUM_MEMI-1:0]          wrap_mi;
    logic [NUM_MEMO-1:0]          wrap_mo;
    logic [CH_WIDTH-1:0]          ch_sel_q;
    logic [CH_WIDTH-1:0]          ch_sel_d;
    logic [NUM_MEMI+NUM_MEMO-1:0] wrap_flags_q;
    logic [NUM_MEMI+NUM_MEMO-1:0] wrap_flags_d;

    // Reset forces every strobe low, so pointers see no increments during reset.
    always_comb begin
        active          = en_s & ~rst_a;
        mo_rd           = active & read  & (conf_dbus == MEM_OUT);
        mi_wr           = active & write & (conf_dbus == MEM_IN);
        wr_en_ConfigReg = active & write & (conf_dbus == CONF_REG);
        en_clear        = active & write & (conf_dbus == STAT_REG);
        cr_ld           = active & write & (conf_dbus == CR_WR_PTR);
        mi_ld           = active & write & (conf_dbus == MI_WR_PTR);
        mo_ld           = active & write & (conf_dbus == MO_RD_PTR);
        ch_ld           = active & write & (conf_dbus == CH_SEL);
    end

    always_comb begin
        case (conf_dbus)
            CONF_REG:  sel_mux = SIZE_MUX'(MUX_CONF);
            MEM_OUT:   sel_mux = SIZE_MUX'(MUX_MEMOUT);
            MEM_IN:    sel_mux = SIZE_MUX'(MUX_MEMIN);
            STAT_REG:  sel_mux = SIZE_MUX'(MUX_STAT);
            CR_WR_PTR: sel_mux = SIZE_MUX'(MUX_CR_PTR);
            MI_WR_PTR: sel_mux = SIZE_MUX'(MUX_MI_PTR);
            MO_RD_PTR: sel_mux = SIZE_MUX'(MUX_MO_PTR);
            CH_SEL:    sel_mux = SIZE_MUX'(MUX_CH_SEL);
            default:   sel_mux = SIZE_MUX'(MUX_ID);
        endcase
    end

    // A channel index with no matching memory selects nothing, so strobes
    // and loads on an out-of-range ch_sel are dropped here.
    generate
        for (genvar gi = 0; gi < NUM_MEMI; gi++) begin : g_memi
            logic hit;
            assign hit             = (ch_sel_q == CH_WIDTH'(gi));
            assign wr_en_MemIn[gi] = mi_wr & hit;

            addr_ptr #(
                .WIDTH (ADDR_WIDTH_MEMI),
                .DEPTH (DEPTH_MEMI)
            ) u_ptr (
                .clk      (clk),
                .srst     (rst_a),
                .load     (mi_ld & hit),
                .load_val (init_ptr[ADDR_WIDTH_MEMI-1:0]),
                .inc      (mi_wr & hit),
                .ptr      (wr_addr_MemIn[gi*ADDR_WIDTH_MEMI +: ADDR_WIDTH_MEMI]),
                .wrap     (wrap_mi[gi])
            );
        end

        for (genvar gi = 0; gi < NUM_MEMO; gi++) begin : g_memo
            logic hit;
            assign hit              = (ch_sel_q == CH_WIDTH'(gi));
            assign rd_en_MemOut[gi] = mo_rd & hit;

            addr_ptr #(
                .WIDTH (ADDR_WIDTH_MEMO),
                .DEPTH (DEPTH_MEMO)
            ) u_ptr (
                .clk      (clk),
                .srst     (rst_a),
                .load     (mo_ld & hit),
                .load_val (init_ptr[ADDR_WIDTH_MEMO-1:0]),
                .inc      (mo_rd & hit),
                .ptr      (rd_addr_MemOut[gi*ADDR_WIDTH_MEMO +: ADDR_WIDTH_MEMO]),
                .wrap     (wrap_mo[gi])
            );
        end
    endgenerate

    addr_ptr #(
        .WIDTH (ADDR_WIDTH_CR),
        .DEPTH (1 << ADDR_WIDTH_CR)
    ) u_cr_ptr (
        .clk      (clk),
        .srst     (rst_a),
        .load     (cr_ld),
        .load_val (init_ptr[ADDR_WIDTH_CR-1:0]),
        .inc      (wr_en_ConfigReg),
        .ptr      (wr_addr_ConfigReg),
        .wrap     ()
    );

    // A wrap arriving together with a clear keeps its flag set.
    always_comb begin
        ch_sel_d     = ch_ld ? init_ptr[CH_WIDTH-1:0] : ch_sel_q;
        wrap_flags_d = en_clear ? '0 : wrap_flags_q;
        wrap_flags_d = wrap_flags_d | {wrap_mo, wrap_mi};
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            ch_sel_q     <= '0;
            wrap_flags_q <= '0;
        end else begin
            ch_sel_q     <= ch_sel_d;
            wrap_flags_q <= wrap_flags_d;
        end
    end

    assign ch_sel     = ch_sel_q;
    assign wrap_flags = wrap_flags_q;

endmodule

// File: tb/tb_ctrl_interface_mc.sv
// Scoreboard bench for ctrl_interface_mc: each step pushes the expected output
// snapshot, the snapshot is popped and compared on the falling edge.
module tb_ctrl_interface_mc;

    localparam logic [4:0] C_CONF = 5'd0, C_MI = 5'd1, C_MO = 5'd2, C_CRP = 5'd3;
    localparam logic [4:0] C_MIP = 5'd4, C_MOP = 5'd5, C_CH = 5'd6, C_STAT = 5'd30;
    localparam logic [4:0] C_ID = 5'd31, C_UNDEF = 5'd17;

    typedef struct packed {
        logic       r;
        logic       w;
        logic       e;
        logic       rst;
        logic [4:0] code;
        logic [5:0] ip;
    } stim_t;

    logic        clk;
    logic        rst_a;
    logic        en_s;
    logic        read;
    logic        write;
    logic [4:0]  conf_dbus;
    logic [5:0]  init_ptr;
    logic [3:0]  sel_mux;
    logic [1:0]  ch_sel;
    logic [0:0]  wr_addr_ConfigReg;
    logic [11:0] wr_addr_MemIn;
    logic [11:0] rd_addr_MemOut;
    logic        wr_en_ConfigReg;
    logic [1:0]  wr_en_MemIn;
    logic [1:0]  rd_en_MemOut;
    logic        en_clear;
    logic [3:0]  wrap_flags;

    logic [40:0] sb[$];
    int          n_cmp;
    int          n_fail;

    ctrl_interface_mc dut (
        .clk               (clk),
        .rst_a             (rst_a),
        .en_s              (en_s),
        .read              (read),
        .write             (write),
        .conf_dbus         (conf_dbus),
        .init_ptr          (init_ptr),
        .sel_mux           (sel_mux),
        .ch_sel            (ch_sel),
        .wr_addr_ConfigReg (wr_addr_ConfigReg),
        .wr_addr_MemIn     (wr_addr_MemIn),
        .rd_addr_MemOut    (rd_addr_MemOut),
        .wr_en_ConfigReg   (wr_en_ConfigReg),
        .wr_en_MemIn       (wr_en_MemIn),
        .rd_en_MemOut      (rd_en_MemOut),
        .en_clear          (en_clear),
        .wrap_flags        (wrap_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t st(input logic r, input logic w, input logic e,
                                 input logic rst, input logic [4:0] code, input int ip);
        stim_t s;
        s.r = r; s.w = w; s.e = e; s.rst = rst; s.code = code; s.ip = 6'(ip);
        return s;
    endfunction

    // Expected snapshot: sel, cr strobe, cr addr, mi strobes, mo strobes,
    // clear, mi1/mi0 addresses, mo1/mo0 addresses, channel, flags.
    function automatic logic [40:0] mk(input int sel, input int cre, input int cra,
                                       input int wen, input int ren, input int clr,
                                       input int mi1, input int mi0, input int mo1,
                                       input int mo0, input int ch, input int fl);
        return {4'(sel), 1'(cre), 1'(cra), 2'(wen), 2'(ren), 1'(clr),
                6'(mi1), 6'(mi0), 6'(mo1), 6'(mo0), 2'(ch), 4'(fl)};
    endfunction

    function automatic logic [40:0] observed();
        return {sel_mux, wr_en_ConfigReg, wr_addr_ConfigReg, wr_en_MemIn, rd_en_MemOut,
                en_clear, wr_addr_MemIn, rd_addr_MemOut, ch_sel, wrap_flags};
    endfunction

    task automatic apply(input stim_t s);
        read      = s.r;
        write     = s.w;
        en_s      = s.e;
        rst_a     = s.rst;
        conf_dbus = s.code;
        init_ptr  = s.ip;
    endtask

    task automatic test_reset();
        stim_t       s[2];
        logic [40:0] e[2];
        logic [40:0] got;
        logic [40:0] want;
        apply(st(0, 1, 1, 1, C_MI, 0));
        repeat (2) @(posedge clk);
        #1;
        s[0] = st(0, 1, 1, 1, C_MI, 0); e[0] = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = st(1, 0, 1, 1, C_MO, 0); e[1] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_reset step %0d: got %h expected %h", i, got, want);
            end else $display("test_reset step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_in_burst();
        stim_t       s[5];
        logic [40:0] e[5];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CH, 1); e[0] = mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = st(0, 1, 1, 0, C_MI, 0); e[1] = mk(4, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        s[2] = st(0, 1, 1, 0, C_MI, 0); e[2] = mk(4, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1, 0);
        s[3] = st(0, 1, 1, 0, C_MI, 0); e[3] = mk(4, 0, 0, 2, 0, 0, 2, 0, 0, 0, 1, 0);
        s[4] = st(0, 0, 1, 0, C_ID, 0); e[4] = mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_mem_in_burst step %0d: got %h expected %h", i, got, want);
            end else $display("test_mem_in_burst step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wrap();
        stim_t       s[6];
        logic [40:0] e[6];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CH, 0);  e[0] = mk(8, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0);
        s[1] = st(0, 1, 1, 0, C_MIP, 62); e[1] = mk(6, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        s[2] = st(0, 1, 1, 0, C_MI, 0);  e[2] = mk(4, 0, 0, 1, 0, 0, 3, 62, 0, 0, 0, 0);
        s[3] = st(0, 1, 1, 0, C_MI, 0);  e[3] = mk(4, 0, 0, 1, 0, 0, 3, 63, 0, 0, 0, 0);
        s[4] = st(0, 1, 1, 0, C_MI, 0);  e[4] = mk(4, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1);
        s[5] = st(0, 0, 1, 0, C_ID, 0);  e[5] = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_wrap step %0d: got %h expected %h", i, got, want);
            end else $display("test_wrap step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flag_clear();
        stim_t       s[3];
        logic [40:0] e[3];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 0, 0, C_STAT, 0); e[0] = mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        s[1] = st(0, 1, 1, 0, C_STAT, 0); e[1] = mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 1);
        s[2] = st(0, 0, 1, 0, C_ID, 0);   e[2] = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_flag_clear step %0d: got %h expected %h", i, got, want);
            end else $display("test_flag_clear step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_out();
        stim_t       s[7];
        logic [40:0] e[7];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CH, 1);  e[0] = mk(8, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        s[1] = st(0, 1, 1, 0, C_MOP, 5); e[1] = mk(7, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0);
        s[2] = st(1, 0, 1, 0, C_MO, 0);  e[2] = mk(3, 0, 0, 0, 2, 0, 3, 1, 5, 0, 1, 0);
        s[3] = st(1, 0, 0, 0, C_MO, 0);  e[3] = mk(3, 0, 0, 0, 0, 0, 3, 1, 6, 0, 1, 0);
        s[4] = st(1, 0, 1, 0, C_MO, 0);  e[4] = mk(3, 0, 0, 0, 2, 0, 3, 1, 6, 0, 1, 0);
        s[5] = st(1, 1, 1, 0, C_MO, 0);  e[5] = mk(3, 0, 0, 0, 2, 0, 3, 1, 7, 0, 1, 0);
        s[6] = st(0, 0, 1, 0, C_ID, 0);  e[6] = mk(0, 0, 0, 0, 0, 0, 3, 1, 8, 0, 1, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_mem_out step %0d: got %h expected %h", i, got, want);
            end else $display("test_mem_out step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_out_of_range();
        stim_t       s[6];
        logic [40:0] e[6];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CH, 3);  e[0] = mk(8, 0, 0, 0, 0, 0, 3, 1, 8, 0, 1, 0);
        s[1] = st(0, 1, 1, 0, C_MI, 0);  e[1] = mk(4, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        s[2] = st(0, 1, 1, 0, C_MIP, 9); e[2] = mk(6, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        s[3] = st(1, 0, 1, 0, C_MO, 0);  e[3] = mk(3, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        s[4] = st(0, 1, 1, 0, C_MOP, 9); e[4] = mk(7, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        s[5] = st(0, 0, 1, 0, C_ID, 0);  e[5] = mk(0, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_out_of_range step %0d: got %h expected %h", i, got, want);
            end else $display("test_out_of_range step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back_reset();
        stim_t       s[7];
        logic [40:0] e[7];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CH, 0);   e[0] = mk(8, 0, 0, 0, 0, 0, 3, 1, 8, 0, 3, 0);
        s[1] = st(0, 1, 1, 0, C_MIP, 63); e[1] = mk(6, 0, 0, 0, 0, 0, 3, 1, 8, 0, 0, 0);
        s[2] = st(0, 1, 1, 0, C_MI, 0);   e[2] = mk(4, 0, 0, 1, 0, 0, 3, 63, 8, 0, 0, 0);
        s[3] = st(0, 1, 1, 0, C_MI, 0);   e[3] = mk(4, 0, 0, 1, 0, 0, 3, 0, 8, 0, 0, 1);
        s[4] = st(0, 1, 1, 0, C_CH, 1);   e[4] = mk(8, 0, 0, 0, 0, 0, 3, 1, 8, 0, 0, 1);
        s[5] = st(0, 1, 1, 1, C_MI, 0);   e[5] = mk(4, 0, 0, 0, 0, 0, 3, 1, 8, 0, 1, 1);
        s[6] = st(0, 0, 1, 0, C_ID, 0);   e[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_back_to_back_reset step %0d: got %h expected %h", i, got, want);
            end else $display("test_back_to_back_reset step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_config();
        stim_t       s[7];
        logic [40:0] e[7];
        logic [40:0] got;
        logic [40:0] want;
        s[0] = st(0, 1, 1, 0, C_CONF, 0);  e[0] = mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[1] = st(0, 1, 1, 0, C_CONF, 0);  e[1] = mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[2] = st(0, 0, 1, 0, C_ID, 0);    e[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[3] = st(0, 1, 1, 0, C_CRP, 1);   e[3] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[4] = st(1, 1, 1, 0, C_UNDEF, 0); e[4] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[5] = st(0, 1, 0, 0, C_CONF, 0);  e[5] = mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[6] = st(0, 0, 1, 0, C_ID, 0);    e[6] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got  = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL test_config step %0d: got %h expected %h", i, got, want);
            end else $display("test_config step %0d: %h ok", i, got);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        apply(st(0, 0, 0, 1, C_ID, 0));
        test_reset();
        test_mem_in_burst();
        test_wrap();
        test_flag_clear();
        test_mem_out();
        test_out_of_range();
        test_back_to_back_reset();
        test_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
